// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, operator and state encodings for the calculator core
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  typedef enum logic [2:0] {CLEAR, READ, DIGIT, CALC, DIV} state_e;

  function automatic op_e key_to_op(input logic [3:0] k);
    case (k)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_divider.sv
// rtl/calc_divider.sv - restoring unsigned W-bit divider, one quotient bit per cycle
// Only compiled when CALC_DIVIDE_EN is defined.
`ifdef CALC_DIVIDE_EN
module calc_divider #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          run_q, done_q;
  logic [W:0]    trial;

  // bit W of the trial difference is the borrow: set means the shifted remainder is below the divisor
  assign trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= divisor;
        cnt_q <= CW'(W);
        run_q <= 1'b1;
      end else if (run_q) begin
        if (!trial[W]) begin
          rem_q <= trial[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= {rem_q[W-2:0], quo_q[W-1]};
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;
endmodule
`endif

// File: rtl/calc_core_param.sv
// rtl/calc_core_param.sv - decimal keypad calculator core with saturating signed W-bit arithmetic
// Define CALC_DIVIDE_EN to add key D (division via calc_divider).
module calc_core_param
  import calc_pkg::*;
#(
  parameter int ARG_DIGITS = 3,
  parameter int W          = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic         key_ready,
  output logic [W-1:0] disp_value,
  output logic         disp_neg,
  output logic         disp_is_result,
  output logic         err,
  output logic         busy
);
  localparam int                    CW      = $clog2(ARG_DIGITS + 1);
  localparam logic [CW-1:0]         MAX_CNT = CW'(ARG_DIGITS);
  localparam logic [W-1:0]          MAX_V   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]          MIN_V   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] MAX_W   = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MIN_W   = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  state_e        state_q, state_d;
  op_e           op_q, op_d, nop_q, nop_d;
  logic [W-1:0]  arg_q, arg_d, result_q, result_d, disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dig_q, dig_d;
  logic          fresh_q, fresh_d, eq_q, eq_d, err_q, err_d, res_q, res_d;

  logic key_acc, is_digit, is_op, is_eq, is_clr;
  op_e  key_op;

  assign key_acc  = key_valid && (state_q == READ);
  assign is_digit = key_code <= 4'd9;
  assign is_clr   = key_code == KEY_CLR;
  assign is_eq    = key_code == KEY_EQ;
  assign key_op   = key_to_op(key_code);
`ifdef CALC_DIVIDE_EN
  assign is_op    = key_code inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV};
`else
  assign is_op    = key_code inside {KEY_ADD, KEY_SUB, KEY_MUL};
`endif

  // arg is unsigned and below 2^(W-1), so zero-extension is its sign extension
  logic signed [2*W-1:0] lhs_w, rhs_w, calc_w;
  logic                  ovf_hi, ovf_lo;
  logic [W-1:0]          sat_v;

  assign lhs_w = {{W{result_q[W-1]}}, result_q};
  assign rhs_w = {{W{1'b0}}, arg_q};

  always_comb begin
    calc_w = lhs_w + rhs_w;
    case (op_q)
      OP_SUB:  calc_w = lhs_w - rhs_w;
      OP_MUL:  calc_w = lhs_w * rhs_w;
      default: ;
    endcase
  end

  assign ovf_hi = calc_w > MAX_W;
  assign ovf_lo = calc_w < MIN_W;
  assign sat_v  = ovf_hi ? MAX_V : (ovf_lo ? MIN_V : calc_w[W-1:0]);

`ifdef CALC_DIVIDE_EN
  logic         div_start, div_done, qneg_q, qneg_d;
  logic [W-1:0] div_mag, div_quot;

  assign div_mag   = result_q[W-1] ? (~result_q + 1'b1) : result_q;
  assign div_start = (state_q == CALC) && (op_q == OP_DIV) && (arg_q != '0);

  calc_divider #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_mag),
    .divisor  (arg_q),
    .quotient (div_quot),
    .done     (div_done)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: state_d = READ;
      READ: begin
        if (key_acc) begin
          if (is_clr) state_d = CLEAR;
          else if (!err_q) begin
            if (is_digit) state_d = DIGIT;
            else if (is_eq || (is_op && (cnt_q != '0 || fresh_q))) state_d = CALC;
          end
        end
      end
      DIGIT: state_d = READ;
      CALC: begin
        state_d = READ;
`ifdef CALC_DIVIDE_EN
        if (div_start) state_d = DIV;
`endif
      end
      DIV: begin
`ifdef CALC_DIVIDE_EN
        if (div_done) state_d = READ;
`else
        state_d = READ;
`endif
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    key_ready = state_q == READ;
    busy      = (state_q == CALC) || (state_q == DIV);
  end

  always_comb begin
    op_d = op_q;  nop_d = nop_q;  arg_d = arg_q;  result_d = result_q;
    disp_d = disp_q;  cnt_d = cnt_q;  dig_d = dig_q;  fresh_d = fresh_q;
    eq_d = eq_q;  err_d = err_q;  res_d = res_q;
`ifdef CALC_DIVIDE_EN
    qneg_d = qneg_q;
`endif
    case (state_q)
      CLEAR: begin
        op_d = OP_ADD;  nop_d = OP_ADD;  arg_d = '0;  result_d = '0;  disp_d = '0;
        cnt_d = '0;  dig_d = '0;  fresh_d = 1'b0;  eq_d = 1'b0;  err_d = 1'b0;  res_d = 1'b0;
      end
      READ: begin
        if (key_acc && !err_q) begin
          if (is_digit) dig_d = key_code;
          else if (is_eq) begin
            nop_d = OP_ADD;
            eq_d  = 1'b1;
          end else if (is_op) begin
            if (cnt_q == '0 && !fresh_q) op_d = key_op;
            else begin
              nop_d = key_op;
              eq_d  = 1'b0;
            end
          end
        end
      end
      DIGIT: begin
        if (fresh_q) begin
          result_d = '0;
          arg_d    = W'(dig_q);
          cnt_d    = CW'(1);
          fresh_d  = 1'b0;
        end else if (cnt_q < MAX_CNT) begin
          arg_d = arg_q * W'(10) + W'(dig_q);
          cnt_d = cnt_q + 1'b1;
        end
        disp_d = arg_d;
        res_d  = 1'b0;
      end
      CALC: begin
        op_d = nop_q;  arg_d = '0;  cnt_d = '0;  fresh_d = eq_q;
`ifdef CALC_DIVIDE_EN
        if (op_q == OP_DIV) begin
          qneg_d = result_q[W-1];
          if (arg_q == '0) begin
            err_d    = 1'b1;
            result_d = result_q[W-1] ? MIN_V : MAX_V;
            disp_d   = result_d;
            res_d    = 1'b1;
          end
        end else
`endif
        begin
          result_d = sat_v;
          disp_d   = sat_v;
          res_d    = 1'b1;
          if (ovf_hi || ovf_lo) err_d = 1'b1;
        end
      end
`ifdef CALC_DIVIDE_EN
      DIV: begin
        if (div_done) begin
          result_d = qneg_q ? (~div_quot + 1'b1) : div_quot;
          disp_d   = result_d;
          res_d    = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_ADD;  nop_q <= OP_ADD;  arg_q <= '0;  result_q <= '0;  disp_q <= '0;
      cnt_q <= '0;  dig_q <= '0;  fresh_q <= 1'b0;  eq_q <= 1'b0;  err_q <= 1'b0;  res_q <= 1'b0;
    end else begin
      op_q <= op_d;  nop_q <= nop_d;  arg_q <= arg_d;  result_q <= result_d;  disp_q <= disp_d;
      cnt_q <= cnt_d;  dig_q <= dig_d;  fresh_q <= fresh_d;  eq_q <= eq_d;  err_q <= err_d;  res_q <= res_d;
    end
  end

`ifdef CALC_DIVIDE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) qneg_q <= 1'b0;
    else     qneg_q <= qneg_d;
  end
`endif

  assign disp_value     = disp_q;
  assign disp_neg       = disp_q[W-1];
  assign disp_is_result = res_q;
  assign err            = err_q;
endmodule

// File: tb/tb_calc_core_param.sv
// tb/tb_calc_core_param.sv - directed vector bench for calc_core_param (W=14, ARG_DIGITS=3)
module tb_calc_core_param;
  import calc_pkg::*;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'h0;
  logic         key_ready, disp_neg, disp_is_result, err, busy;
  logic [W-1:0] disp_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_core_param #(.ARG_DIGITS(3), .W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_ready      (key_ready),
    .disp_value     (disp_value),
    .disp_neg       (disp_neg),
    .disp_is_result (disp_is_result),
    .err            (err),
    .busy           (busy)
  );

  // keys are packed first-key-in-MSB nibble, n of them used
  typedef struct packed {
    logic [31:0]  keys;
    logic [3:0]   n;
    logic [W-1:0] disp;
    logic         res;
    logic         err;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) begin
      checks++;
      errors++;
      $display("FAIL key_ready timeout: got 0 expected 1");
    end
  endtask

  task automatic press(input logic [3:0] k);
    wait_ready();
    @(negedge clk);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    wait_ready();
  endtask

  task automatic press_seq(input logic [31:0] keys, input int n);
    for (int j = 0; j < n; j++) press(keys[31-4*j -: 4]);
  endtask

  initial begin
    vt[0]  = '{32'h12A34F00, 4'd6, 14'd46,    1'b1, 1'b0};
    vt[1]  = '{32'h5B9F0000, 4'd4, 14'h3FFC,  1'b1, 1'b0};
    vt[2]  = '{32'h12340000, 4'd4, 14'd123,   1'b0, 1'b0};
    vt[3]  = '{32'h999C9F00, 4'd6, 14'd8191,  1'b1, 1'b1};
    vt[4]  = '{32'h7AB2F000, 4'd5, 14'd5,     1'b1, 1'b0};
    vt[5]  = '{32'h2C3F0000, 4'd4, 14'd6,     1'b1, 1'b0};
    vt[6]  = '{32'h4FC5F000, 4'd5, 14'd20,    1'b1, 1'b0};
    vt[7]  = '{32'h3F800000, 4'd3, 14'd8,     1'b0, 1'b0};
    vt[8]  = '{32'h1B999C9F, 4'd8, 14'h2000,  1'b1, 1'b1};
    vt[9]  = '{32'h00570000, 4'd4, 14'd5,     1'b0, 1'b0};
    vt[10] = '{32'hF0000000, 4'd1, 14'd0,     1'b1, 1'b0};
`ifdef CALC_DIVIDE_EN
    vt[11] = '{32'h6D2F0000, 4'd4, 14'd3,     1'b1, 1'b0};
`else
    vt[11] = '{32'h6D2F0000, 4'd4, 14'd62,    1'b1, 1'b0};
`endif

    repeat (2) @(negedge clk);
    chk("reset key_ready", key_ready, 0);
    chk("reset disp", disp_value, 0);
    chk("reset res", disp_is_result, 0);
    chk("reset err", err, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    wait_ready();

    for (int i = 0; i < 12; i++) begin
      press(KEY_CLR);
      press_seq(vt[i].keys, int'(vt[i].n));
      chk($sformatf("vec%0d disp", i), disp_value, vt[i].disp);
      chk($sformatf("vec%0d res", i), disp_is_result, vt[i].res);
      chk($sformatf("vec%0d err", i), err, vt[i].err);
      chk($sformatf("vec%0d neg", i), disp_neg, vt[i].disp[W-1]);
    end

    // digit shows exactly one cycle after acceptance
    press(KEY_CLR);
    @(negedge clk);
    key_code  = 4'd7;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    chk("latency disp before", disp_value, 0);
    chk("latency ready low", key_ready, 0);
    @(posedge clk);
    #1;
    chk("latency disp after", disp_value, 7);
    chk("latency ready back", key_ready, 1);

    // error state ignores everything but clear
    press(KEY_CLR);
    press_seq(32'h999C9F00, 6);
    press(4'd5);
    chk("err drop disp", disp_value, 8191);
    chk("err drop err", err, 1);
    press(KEY_CLR);
    chk("clear disp", disp_value, 0);
    chk("clear err", err, 0);

    // strobe during calculation is dropped
    press(KEY_CLR);
    press(4'd3);
    @(negedge clk);
    key_code  = KEY_EQ;
    key_valid = 1'b1;
    @(negedge clk);
    key_code  = 4'd9;
    chk("busy during calc", busy, 1);
    chk("ready during calc", key_ready, 0);
    @(negedge clk);
    key_valid = 1'b0;
    wait_ready();
    chk("busy drop disp", disp_value, 3);
    chk("busy drop res", disp_is_result, 1);

`ifdef CALC_DIVIDE_EN
    begin
      int nb;
      press(KEY_CLR);
      press_seq(32'h100D7000, 5);
      @(negedge clk);
      key_code  = KEY_EQ;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      nb = 0;
      while (busy && nb < 100) begin
        nb++;
        @(negedge clk);
      end
      // one CALC cycle plus W+1 DIV cycles
      chk("div busy cycles", nb, W + 2);
      chk("div quotient", disp_value, 14);
      chk("div res", disp_is_result, 1);

      press(KEY_CLR);
      press_seq(32'h5D0F0000, 4);
      chk("div0 err", err, 1);
      chk("div0 disp", disp_value, 8191);

      press(KEY_CLR);
      press_seq(32'h100D7000, 5);
      @(negedge clk);
      key_code  = KEY_EQ;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid div busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst mid div busy", busy, 0);
      chk("rst mid div ready", key_ready, 0);
      chk("rst mid div disp", disp_value, 0);
      chk("rst mid div res", disp_is_result, 0);
      chk("rst mid div err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
